mul_share_arbiter: RTL and testbench

// - Arbitrates one signed multiplier (plus adder) between two requesters.
//   - Requester A computes x1*x2.
//   - Requester B computes v*t + c.
// - Sits between the stimulus/requester logic and the shared datapath.
// - Gated by BIST: no grants are issued until the BIST asserts enable_normal.
// - Round-robin fairness; one operation in flight; registered request/grant handshake.

---
 rtl/mul_share_pkg.sv | 18 +
 rtl/mul_pipe.sv | 43 ++++
 rtl/mul_share_arbiter.sv | 127 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MUL_LAT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage

// File: rtl/mul_pipe.sv
// Signed multiply-add x*y + addend, delivered after MUL_LAT register stages.
module mul_pipe
    import mul_share_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   x,
    input  logic signed [WIDTH-1:0]   y,
    input  logic signed [WIDTH-1:0]   addend,
    output logic signed [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] stage [MUL_LAT];

    // The true result always fits PW bits, so a PW-bit wrap is exact.
    assign xe = PW'(x);
    assign ye = PW'(y);
    assign ce = PW'(addend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= xe * ye + ce;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one signed multiply-add between requester A (x1*x2)
// and requester B (v*t + c); one operation in flight, grants gated by enable.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      req_a,
    input  logic signed [WIDTH-1:0]   a_x1,
    input  logic signed [WIDTH-1:0]   a_x2,
    input  logic                      req_b,
    input  logic signed [WIDTH-1:0]   b_v,
    input  logic signed [WIDTH-1:0]   b_t,
    input  logic signed [WIDTH-1:0]   b_c,
    output logic                      gnt_a,
    output logic                      gnt_b,
    output logic signed [2*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      out_src,
    output logic                      busy
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t                     state, state_d;
    logic [CW-1:0]              cnt, cnt_d;
    src_t                       last_served, last_d;
    src_t                       src_q, src_d;
    logic                       gnt_a_d, gnt_b_d, ov_d;
    logic signed [2*WIDTH-1:0]  out_d;
    logic                       pick_a, start;
    logic signed [WIDTH-1:0]    op_x, op_y, op_c;
    logic signed [2*WIDTH-1:0]  prod;

    // On a tie the requester not served last time wins.
    assign pick_a = req_a && !(req_b && last_served == SRC_A);
    assign start  = enable && (req_a || req_b);

    assign op_x = pick_a ? a_x1 : b_v;
    assign op_y = pick_a ? a_x2 : b_t;
    assign op_c = pick_a ? '0   : b_c;

    // The pipe's first stage samples every edge; on the grant edge it holds the
    // winner's operands, which reach the last stage just before the DONE edge.
    mul_pipe #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_pipe (
        .clk    (clk),
        .reset  (reset),
        .x      (op_x),
        .y      (op_y),
        .addend (op_c),
        .p      (prod)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last_d  = last_served;
        src_d   = src_q;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        ov_d    = 1'b0;
        out_d   = out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    src_d   = pick_a ? SRC_A : SRC_B;
                    last_d  = pick_a ? SRC_A : SRC_B;
                    gnt_a_d = pick_a;
                    gnt_b_d = !pick_a;
                end
            end
            CALC: begin
                if (cnt == CW'(MUL_LAT - 1)) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                    out_d   = prod;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_served <= SRC_B;
            src_q       <= SRC_A;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            out_valid   <= 1'b0;
            out         <= '0;
            out_src     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last_served <= last_d;
            src_q       <= src_d;
            gnt_a       <= gnt_a_d;
            gnt_b       <= gnt_b_d;
            out_valid   <= ov_d;
            out         <= out_d;
            if (ov_d) begin
                out_src <= src_q;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: a time-based model predicts grants,
// busy windows and results; a monitor compares them against the DUT each cycle.
module tb_mul_share_arbiter;

    localparam int W    = 8;
    localparam int L    = 2;
    localparam int MAXE = 4096;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b1;
    logic                    req_a = 1'b0, req_b = 1'b0;
    logic signed [W-1:0]     a_x1 = '0, a_x2 = '0, b_v = '0, b_t = '0, b_c = '0;
    logic                    gnt_a, gnt_b, out_valid, out_src, busy;
    logic signed [2*W-1:0]   out;

    mul_share_arbiter #(.WIDTH(W), .MUL_LAT(L)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_a(req_a), .a_x1(a_x1), .a_x2(a_x2),
        .req_b(req_b), .b_v(b_v), .b_t(b_t), .b_c(b_c),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .out(out), .out_valid(out_valid),
        .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { bit src; int val; } exp_t;
    exp_t sb[$];
    bit   eg_a[MAXE], eg_b[MAXE], eov[MAXE], ebusy[MAXE];
    int   hold_val = 0;

    // model state: cycles until the arbiter can grant again, and last winner
    int   cd = 0;
    bit   last_b = 1'b1;
    bit   gr_a_prev = 1'b0, gr_b_prev = 1'b0;
    bit   rel_pending = 1'b0;

    // requester policy
    bit   rnd = 1'b0;
    bit   en_cmd = 1'b1;
    int   a_cnt = 0, b_cnt = 0;
    logic signed [W-1:0] fa1 = 8'sd10, fa2 = 8'sd2, fbv = 8'sd8, fbt = 8'sd3, fbc = -8'sd2;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int e;
        bit wb;
        @(negedge clk);
        if (rel_pending) begin
            reset = 1'b0;
            rel_pending = 1'b0;
        end
        if (gr_a_prev) req_a = 1'b0;
        if (gr_b_prev) req_b = 1'b0;
        gr_a_prev = 1'b0;
        gr_b_prev = 1'b0;
        if (rnd) begin
            if (req_a && $urandom_range(0, 15) == 0) req_a = 1'b0;
            if (req_b && $urandom_range(0, 15) == 0) req_b = 1'b0;
            if (!req_a && $urandom_range(0, 2) == 0) begin
                req_a = 1'b1; a_x1 = W'($urandom); a_x2 = W'($urandom);
            end
            if (!req_b && $urandom_range(0, 2) == 0) begin
                req_b = 1'b1; b_v = W'($urandom); b_t = W'($urandom); b_c = W'($urandom);
            end
            if ($urandom_range(0, 19) == 0) enable = ~enable;
        end else begin
            enable = en_cmd;
            if (!req_a && a_cnt > 0) begin
                req_a = 1'b1; a_x1 = fa1; a_x2 = fa2; a_cnt--;
            end
            if (!req_b && b_cnt > 0) begin
                req_b = 1'b1; b_v = fbv; b_t = fbt; b_c = fbc; b_cnt--;
            end
        end
        e = edge_cnt + 1;
        if (cd > 0) begin
            cd--;
        end else if (!reset && enable && (req_a || req_b) && e + L < MAXE) begin
            wb = (req_a && req_b) ? !last_b : req_b;
            last_b = wb;
            cd = L + 1;
            if (wb) begin
                eg_b[e] = 1'b1; gr_b_prev = 1'b1;
                sb.push_back('{1'b1, int'(b_v) * int'(b_t) + int'(b_c)});
            end else begin
                eg_a[e] = 1'b1; gr_a_prev = 1'b1;
                sb.push_back('{1'b0, int'(a_x1) * int'(a_x2)});
            end
            for (int k = 0; k <= L; k++) ebusy[e + k] = 1'b1;
            eov[e + L] = 1'b1;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        sb.delete();
        hold_val = 0; cd = 0; last_b = 1'b1;
        gr_a_prev = 1'b0; gr_b_prev = 1'b0;
        for (int e = edge_cnt + 1; e < MAXE; e++) begin
            eg_a[e] = 1'b0; eg_b[e] = 1'b0; eov[e] = 1'b0; ebusy[e] = 1'b0;
        end
        #1;
        check_reset_outputs();
        repeat (cycles) step();
        rel_pending = 1'b1;
    endtask

    // monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (edge_cnt < MAXE) begin
                chk("gnt_a", gnt_a, eg_a[edge_cnt]);
                chk("gnt_b", gnt_b, eg_b[edge_cnt]);
                chk("out_valid", out_valid, eov[edge_cnt]);
                chk("busy", busy, ebusy[edge_cnt]);
                if (out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_result: got out=%0d expected no result", out);
                    end else begin
                        x = sb.pop_front();
                        chk("out", out, x.val);
                        chk("out_src", out_src, x.src);
                        hold_val = x.val;
                    end
                end else begin
                    chk("out_hold", out, hold_val);
                end
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        rel_pending = 1'b1;

        // single A request, then single B request
        a_cnt = 1;
        repeat (7) step();
        b_cnt = 1;
        repeat (7) step();

        // both held from reset: A, B alternating
        a_cnt = 3; b_cnt = 3;
        do_reset(2);
        repeat (30) step();

        // enable low blocks grants, then raised
        en_cmd = 1'b0; a_cnt = 1;
        repeat (10) step();
        en_cmd = 1'b1;
        repeat (7) step();

        // operand extremes
        fa1 = -8'sd128; fa2 = -8'sd128; a_cnt = 1;
        repeat (7) step();
        fbv = -8'sd128; fbt = 8'sd127; fbc = -8'sd128; b_cnt = 1;
        repeat (7) step();

        // reset while an operation is in CALC, then a tie
        fa1 = 8'sd10; fa2 = 8'sd2; fbv = 8'sd8; fbt = 8'sd3; fbc = -8'sd2;
        a_cnt = 1;
        for (int i = 0; i < 10 && !gr_a_prev; i++) step();
        chk("grant_before_reset", gr_a_prev, 1);
        a_cnt = 1; b_cnt = 1;
        do_reset(2);
        repeat (10) step();

        // randomized traffic
        rnd = 1'b1;
        repeat (600) step();

        // drain
        rnd = 1'b0; en_cmd = 1'b1; a_cnt = 0; b_cnt = 0;
        repeat (12) step();
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
